// File: rtl/divider2_control_pkg.sv
// Shared types and constants for the divider2 datapath and its sequencing controller.
package divider2Pkg;

   localparam int DIV_ITERATIONS = 32;

   typedef enum logic {
      DIVISOR_IN,
      NEG_DIVISOR_IN
   } divisorMux;

   typedef enum logic [2:0] {
      REM_DIVIDEND,
      REM_NEG_DIVIDEND,
      REM_SHIFT_SUB,
      REM_SHIFT_KEEP,
      REM_NEGATE
   } remainderMux;

   typedef enum logic [1:0] {
      QUO_CLEAR,
      QUO_SHIFT_IN,
      QUO_ALL_ONES,
      QUO_NEGATE
   } quotientMux;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIVIDE,
      S_FIXUP,
      S_DBZ,
      S_DONE
   } divCtrlState;

endpackage

// File: rtl/divider2_control_counter.sv
// Loadable iteration down-counter; holds at zero and flags it.
module divIterCounter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/divider2_control.sv
// Sequencing controller for the radix-2 restoring divider: operand load,
// iteration, sign fix-up, divide-by-zero and flush handling.
module divider2_control
   import divider2Pkg::*;
#(
   parameter int ITERATIONS = DIV_ITERATIONS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        signedOp,
   input  logic        flush,
   input  logic        dividendSign,
   input  logic        divisorSign,
   input  logic        divisorZero,
   input  logic        trialNeg,
   output logic        divisorEn,
   output divisorMux   divisorSel,
   output logic        remainderEn,
   output remainderMux remainderSel,
   output logic        quotientEn,
   output quotientMux  quotientSel,
   output logic        quotientBit,
   output logic        busy,
   output logic        done,
   output logic        divByZero
);

   localparam int CW = $clog2(ITERATIONS);

   divCtrlState state, state_next;
   logic        q_neg, r_neg, dbz_flag;
   logic        cnt_load, cnt_dec, cnt_zero;
   logic        accept;

   divIterCounter #(.WIDTH(CW)) u_counter (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .load       (cnt_load),
      .load_value (CW'(ITERATIONS - 1)),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   assign accept = (state == S_IDLE) && start && !divisorZero && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         dbz_flag <= 1'b0;
      end else begin
         state <= state_next;
         if (flush) begin
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dbz_flag <= 1'b0;
         end else begin
            if (accept) begin
               q_neg <= signedOp & (dividendSign ^ divisorSign);
               r_neg <= signedOp & dividendSign;
            end
            if (state == S_DBZ) begin
               dbz_flag <= 1'b1;
            end else if (state == S_DONE) begin
               dbz_flag <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_next   = state;
      divisorEn    = 1'b0;
      divisorSel   = DIVISOR_IN;
      remainderEn  = 1'b0;
      remainderSel = REM_DIVIDEND;
      quotientEn   = 1'b0;
      quotientSel  = QUO_CLEAR;
      quotientBit  = 1'b0;
      done         = 1'b0;
      divByZero    = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      busy         = (state != S_IDLE);

      case (state)
         S_IDLE: begin
            if (start) begin
               if (!divisorZero) begin
                  divisorEn    = 1'b1;
                  divisorSel   = (signedOp & divisorSign) ? NEG_DIVISOR_IN : DIVISOR_IN;
                  remainderEn  = 1'b1;
                  remainderSel = (signedOp & dividendSign) ? REM_NEG_DIVIDEND : REM_DIVIDEND;
                  quotientEn   = 1'b1;
                  quotientSel  = QUO_CLEAR;
                  cnt_load     = 1'b1;
                  state_next   = S_DIVIDE;
               end else begin
                  state_next = S_DBZ;
               end
            end
         end
         S_DIVIDE: begin
            remainderEn  = 1'b1;
            remainderSel = trialNeg ? REM_SHIFT_KEEP : REM_SHIFT_SUB;
            quotientEn   = 1'b1;
            quotientSel  = QUO_SHIFT_IN;
            quotientBit  = ~trialNeg;
            cnt_dec      = 1'b1;
            if (cnt_zero) begin
               state_next = S_FIXUP;
            end
         end
         S_FIXUP: begin
            quotientEn   = q_neg;
            quotientSel  = q_neg ? QUO_NEGATE : QUO_CLEAR;
            remainderEn  = r_neg;
            remainderSel = r_neg ? REM_NEGATE : REM_DIVIDEND;
            state_next   = S_DONE;
         end
         S_DBZ: begin
            quotientEn   = 1'b1;
            quotientSel  = QUO_ALL_ONES;
            remainderEn  = 1'b1;
            remainderSel = REM_DIVIDEND;
            state_next   = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            divByZero  = dbz_flag;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      // Flush overrides everything decided above, including the IDLE load.
      if (flush) begin
         state_next   = S_IDLE;
         divisorEn    = 1'b0;
         divisorSel   = DIVISOR_IN;
         remainderEn  = 1'b0;
         remainderSel = REM_DIVIDEND;
         quotientEn   = 1'b0;
         quotientSel  = QUO_CLEAR;
         quotientBit  = 1'b0;
         done         = 1'b0;
         divByZero    = 1'b0;
         cnt_load     = 1'b0;
         cnt_dec      = 1'b0;
      end
   end

endmodule

// File: tb/tb_divider2_control.sv
// Directed bench for divider2_control driving a behavioural divider datapath.
module tb_divider2_control;
   import divider2Pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        signedOp = 1'b0;
   logic        flush = 1'b0;
   logic        trialNeg;
   logic        divisorEn, remainderEn, quotientEn, quotientBit, busy, done, divByZero;
   divisorMux   divisorSel;
   remainderMux remainderSel;
   quotientMux  quotientSel;

   logic [31:0] dividend = '0;
   logic [31:0] divisor_op = '0;

   int tests = 0;
   int fails = 0;

   divider2_control #(.ITERATIONS(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .signedOp     (signedOp),
      .flush        (flush),
      .dividendSign (dividend[31]),
      .divisorSign  (divisor_op[31]),
      .divisorZero  (divisor_op == 32'd0),
      .trialNeg     (trialNeg),
      .divisorEn    (divisorEn),
      .divisorSel   (divisorSel),
      .remainderEn  (remainderEn),
      .remainderSel (remainderSel),
      .quotientEn   (quotientEn),
      .quotientSel  (quotientSel),
      .quotientBit  (quotientBit),
      .busy         (busy),
      .done         (done),
      .divByZero    (divByZero)
   );

   always #5 clk = ~clk;

   // Datapath: 64-bit {hi,lo} remainder shifting left, lo holds the dividend magnitude.
   logic [31:0] dv = '0, hi = '0, lo = '0, quo = '0;
   logic [32:0] shifted;
   logic [33:0] diff;

   always_comb begin
      shifted  = {hi, lo[31]};
      diff     = {1'b0, shifted} - {2'b00, dv};
      trialNeg = diff[33];
   end

   always @(posedge clk) begin
      if (divisorEn)
         dv <= (divisorSel == NEG_DIVISOR_IN) ? -divisor_op : divisor_op;
      if (remainderEn) begin
         case (remainderSel)
            REM_DIVIDEND:     begin hi <= '0; lo <= dividend; end
            REM_NEG_DIVIDEND: begin hi <= '0; lo <= -dividend; end
            REM_SHIFT_SUB:    begin hi <= diff[31:0]; lo <= {lo[30:0], 1'b0}; end
            REM_SHIFT_KEEP:   begin hi <= shifted[31:0]; lo <= {lo[30:0], 1'b0}; end
            REM_NEGATE:       hi <= -hi;
            default:          ;
         endcase
      end
      if (quotientEn) begin
         case (quotientSel)
            QUO_CLEAR:    quo <= '0;
            QUO_SHIFT_IN: quo <= {quo[30:0], quotientBit};
            QUO_ALL_ONES: quo <= '1;
            QUO_NEGATE:   quo <= -quo;
            default:      ;
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Results of the last run and load-cycle observations.
   logic [31:0] res_q, res_r;
   logic        res_dbz;
   int          done_at, busy_cycles, done_cycles;
   logic [31:0] ld_dsel, ld_rsel, ld_en;
   logic [31:0] flush_en, reset_outs;
   int          inj_start = 0, inj_flush = 0, inj_reset = 0;

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      dividend = a; divisor_op = b; signedOp = s; start = 1'b1;
      #1;
      ld_dsel = 32'(divisorSel);
      ld_rsel = 32'(remainderSel);
      ld_en   = {29'd0, divisorEn, remainderEn, quotientEn};
      done_at = 0; busy_cycles = 0; done_cycles = 0;
      res_q = '0; res_r = '0; res_dbz = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (reset) begin
            if (busy) busy_cycles++;
            if (done) begin
               done_cycles++;
               if (done_at == 0) begin
                  done_at = cyc;
                  res_q   = quo;
                  res_r   = hi | lo;
                  res_dbz = divByZero;
               end
            end
         end
         if (!busy && cyc > 1) break;
         if (cyc == inj_start) start = 1'b1;
         if (cyc == inj_start + 1) start = 1'b0;
         if (cyc == inj_flush) begin
            flush = 1'b1;
            #1 flush_en = {29'd0, divisorEn, remainderEn, quotientEn} | {31'd0, done};
         end
         if (cyc == inj_reset) begin
            #2 reset = 1'b0;
            #1 reset_outs = {19'd0, divisorEn, divisorSel, remainderEn, remainderSel,
                             quotientEn, quotientSel, quotientBit, busy, done, divByZero};
         end
         @(negedge clk);
         flush = 1'b0;
         reset = 1'b1;
      end
      inj_start = 0; inj_flush = 0; inj_reset = 0;
   endtask

   initial begin
      #12;
      chk("reset_outputs", {19'd0, divisorEn, divisorSel, remainderEn, remainderSel,
                            quotientEn, quotientSel, quotientBit, busy, done, divByZero}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Unsigned 100 / 7
      run_div(32'd100, 32'd7, 1'b0);
      chk("u100_7_load_en", ld_en, 32'h7);
      chk("u100_7_latency", 32'(done_at), 32'd34);
      chk("u100_7_busy_cycles", 32'(busy_cycles), 32'd34);
      chk("u100_7_done_width", 32'(done_cycles), 32'd1);
      chk("u100_7_quotient", res_q, 32'd14);
      chk("u100_7_remainder", res_r, 32'd2);
      chk("u100_7_dbz", {31'd0, res_dbz}, 32'd0);

      // Signed -100 / 7
      run_div(-32'sd100, 32'd7, 1'b1);
      chk("s_m100_7_divisorSel", ld_dsel, 32'(DIVISOR_IN));
      chk("s_m100_7_remainderSel", ld_rsel, 32'(REM_NEG_DIVIDEND));
      chk("s_m100_7_quotient", res_q, 32'hFFFF_FFF2);
      chk("s_m100_7_remainder", res_r, 32'hFFFF_FFFE);

      // Signed overflow -2^31 / -1
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("ovf_divisorSel", ld_dsel, 32'(NEG_DIVISOR_IN));
      chk("ovf_quotient", res_q, 32'h8000_0000);
      chk("ovf_remainder", res_r, 32'd0);
      chk("ovf_dbz", {31'd0, res_dbz}, 32'd0);

      // Unsigned 0xFFFFFFFF / 16
      run_div(32'hFFFF_FFFF, 32'd16, 1'b0);
      chk("u_max_16_quotient", res_q, 32'h0FFF_FFFF);
      chk("u_max_16_remainder", res_r, 32'd15);

      // Divide by zero
      run_div(32'h1234_5678, 32'd0, 1'b0);
      chk("dbz_load_en", ld_en, 32'd0);
      chk("dbz_latency", 32'(done_at), 32'd2);
      chk("dbz_flag", {31'd0, res_dbz}, 32'd1);
      chk("dbz_quotient", res_q, 32'hFFFF_FFFF);
      chk("dbz_remainder", res_r, 32'h1234_5678);

      // Re-start during DIVIDE is ignored
      inj_start = 10;
      run_div(32'd100, 32'd7, 1'b0);
      chk("restart_latency", 32'(done_at), 32'd34);
      chk("restart_done_width", 32'(done_cycles), 32'd1);
      chk("restart_quotient", res_q, 32'd14);
      chk("restart_remainder", res_r, 32'd2);
      chk("after_restart_idle", {31'd0, busy}, 32'd0);

      // Flush at iteration 20
      flush_en = 32'hDEAD;
      inj_flush = 20;
      run_div(32'd100, 32'd7, 1'b0);
      chk("flush_enables", flush_en, 32'd0);
      chk("flush_busy_cycles", 32'(busy_cycles), 32'd20);
      chk("flush_no_done", 32'(done_cycles), 32'd0);
      run_div(32'd9, 32'd3, 1'b0);
      chk("post_flush_quotient", res_q, 32'd3);
      chk("post_flush_remainder", res_r, 32'd0);
      chk("post_flush_latency", 32'(done_at), 32'd34);

      // Flush together with start in IDLE drops the start
      dividend = 32'd9; divisor_op = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush_start_dropped", {31'd0, busy}, 32'd0);

      // Asynchronous reset during FIXUP
      reset_outs = 32'hDEAD;
      inj_reset = 33;
      run_div(32'd100, 32'd7, 1'b0);
      chk("reset_fixup_outputs", reset_outs, 32'd0);
      chk("reset_fixup_no_done", 32'(done_cycles), 32'd0);
      run_div(-32'sd7, 32'd2, 1'b1);
      chk("post_reset_quotient", res_q, 32'hFFFF_FFFD);
      chk("post_reset_remainder", res_r, 32'hFFFF_FFFF);
      chk("post_reset_latency", 32'(done_at), 32'd34);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
